// File: rtl/mem_arbiter_pkg.sv
// Shared CPU/memory types for the cache-to-RAM arbitration path.
// Declares the RAM handshake state and the arbiter FSM state.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DGRANT = 2'b01,
        IGRANT = 2'b10,
        HOLD   = 2'b11
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: the first asserted request at or after ptr, walking upward
// and wrapping, gets a one-hot grant.
module rr_arbiter
    import cpu_types_pkg::*;
#(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr) + i) % N);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Responder end of cache_control_if: arbitrates NCPU i/d cache channels onto one RAM port.
// Define MEM_ARBITER_STATS_EN to add per-core grant counters on ports istat/dstat.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NCPU    = 2,
    parameter int RAM_LAT = 0
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [NCPU-1:0]      iREN,
    input  logic [NCPU*32-1:0]   iaddr,
    output logic [NCPU-1:0]      iwait,
    output logic [NCPU*32-1:0]   iload,
    input  logic [NCPU-1:0]      dREN,
    input  logic [NCPU-1:0]      dWEN,
    input  logic [NCPU*32-1:0]   daddr,
    input  logic [NCPU*32-1:0]   dstore,
    output logic [NCPU-1:0]      dwait,
    output logic [NCPU*32-1:0]   dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  logic [1:0]           ramstate
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [NCPU*32-1:0]   istat,
    output logic [NCPU*32-1:0]   dstat
`endif
);

    localparam int CW = (NCPU > 1) ? $clog2(NCPU) : 1;

    arb_state_t    state;
    logic [CW-1:0] rr_ptr;
    logic [CW-1:0] gnt_cpu;
    logic          gnt_is_d;
    logic [31:0]   hold_cnt;

    logic [NCPU-1:0] dreq, d_gnt, i_gnt, sel_oh;
    logic            d_valid, i_valid;
    logic [CW-1:0]   sel_idx;

    logic  g_iren, g_dren, g_dwen;
    word_t g_iaddr, g_daddr, g_dstore;
    logic  granted, active, done;

    assign dreq = dREN | dWEN;

    rr_arbiter #(.N(NCPU)) u_d_arb (
        .req   (dreq),
        .ptr   (rr_ptr),
        .gnt   (d_gnt),
        .valid (d_valid)
    );

    rr_arbiter #(.N(NCPU)) u_i_arb (
        .req   (iREN),
        .ptr   (rr_ptr),
        .gnt   (i_gnt),
        .valid (i_valid)
    );

    always_comb begin
        sel_oh  = d_valid ? d_gnt : i_gnt;
        sel_idx = '0;
        for (int unsigned c = 0; c < NCPU; c++)
            if (sel_oh[c]) sel_idx = CW'(c);
    end

    // Live request lines of the granted core; dropping them aborts the grant.
    always_comb begin
        g_iren   = 1'b0;
        g_dren   = 1'b0;
        g_dwen   = 1'b0;
        g_iaddr  = '0;
        g_daddr  = '0;
        g_dstore = '0;
        for (int unsigned c = 0; c < NCPU; c++) begin
            if (CW'(c) == gnt_cpu) begin
                g_iren   = iREN[c];
                g_dren   = dREN[c];
                g_dwen   = dWEN[c];
                g_iaddr  = iaddr[c*32 +: 32];
                g_daddr  = daddr[c*32 +: 32];
                g_dstore = dstore[c*32 +: 32];
            end
        end
    end

    assign granted = (state == DGRANT) || (state == IGRANT);
    assign active  = granted && (gnt_is_d ? (g_dren || g_dwen) : g_iren);
    assign done    = active && (ramstate == ACCESS);

    always_comb begin
        ramREN   = active && (gnt_is_d ? (g_dren && !g_dwen) : 1'b1);
        ramWEN   = active && gnt_is_d && g_dwen;
        ramaddr  = active ? (gnt_is_d ? g_daddr : g_iaddr) : '0;
        ramstore = ramWEN ? g_dstore : '0;
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        for (int unsigned c = 0; c < NCPU; c++) begin
            if (done && CW'(c) == gnt_cpu) begin
                if (gnt_is_d) begin
                    dwait[c] = 1'b0;
                    if (!g_dwen) dload[c*32 +: 32] = ramload;
                end else begin
                    iwait[c] = 1'b0;
                    iload[c*32 +: 32] = ramload;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_cpu  <= '0;
            gnt_is_d <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_valid || i_valid) begin
                        gnt_cpu  <= sel_idx;
                        gnt_is_d <= d_valid;
                        state    <= d_valid ? DGRANT : IGRANT;
                    end
                end
                DGRANT, IGRANT: begin
                    if (!active) begin
                        state <= IDLE;
                    end else if (done) begin
                        rr_ptr <= (gnt_cpu == CW'(NCPU - 1)) ? '0 : gnt_cpu + 1'b1;
                        if (RAM_LAT == 0) begin
                            state <= IDLE;
                        end else begin
                            state    <= HOLD;
                            hold_cnt <= 32'(RAM_LAT - 1);
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) state <= IDLE;
                    else                hold_cnt <= hold_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] istat_cnt [NCPU];
    logic [31:0] dstat_cnt [NCPU];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned c = 0; c < NCPU; c++) begin
                istat_cnt[c] <= '0;
                dstat_cnt[c] <= '0;
            end
        end else if (done) begin
            for (int unsigned c = 0; c < NCPU; c++) begin
                if (CW'(c) == gnt_cpu) begin
                    if (gnt_is_d) dstat_cnt[c] <= dstat_cnt[c] + 32'd1;
                    else          istat_cnt[c] <= istat_cnt[c] + 32'd1;
                end
            end
        end
    end

    for (genvar c = 0; c < NCPU; c++) begin : g_stat
        assign istat[c*32 +: 32] = istat_cnt[c];
        assign dstat[c*32 +: 32] = dstat_cnt[c];
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, d-over-i priority, round-robin,
// abort/error, write/read data paths and (with MEM_ARBITER_STATS_EN) grant counters.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int NCPU = 2;

    logic              CLK;
    logic              nRST;
    logic [NCPU-1:0]   iREN;
    logic [NCPU*32-1:0] iaddr;
    logic [NCPU-1:0]   iwait;
    logic [NCPU*32-1:0] iload;
    logic [NCPU-1:0]   dREN;
    logic [NCPU-1:0]   dWEN;
    logic [NCPU*32-1:0] daddr;
    logic [NCPU*32-1:0] dstore;
    logic [NCPU-1:0]   dwait;
    logic [NCPU*32-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [31:0]       ramaddr;
    logic [31:0]       ramstore;
    logic [31:0]       ramload;
    logic [1:0]        ramstate;
`ifdef MEM_ARBITER_STATS_EN
    logic [NCPU*32-1:0] istat;
    logic [NCPU*32-1:0] dstat;
`endif

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.NCPU(NCPU), .RAM_LAT(0)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .istat    (istat),
        .dstat    (dstat)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 2 time units after the rising edge.
    task automatic step;
        @(posedge CLK);
        #2;
    endtask

    initial begin
        nRST = 1'b0;  iREN = '0;  iaddr = '0;  dREN = '0;  dWEN = '0;
        daddr = '0;   dstore = '0; ramload = '0; ramstate = FREE;

        // 1: reset values
        #1;
        chk("rst_iwait",   32'(iwait),  32'h3);
        chk("rst_dwait",   32'(dwait),  32'h3);
        chk("rst_ramREN",  32'(ramREN), 32'h0);
        chk("rst_ramWEN",  32'(ramWEN), 32'h0);
        chk("rst_iload",   iload[31:0] | iload[63:32], 32'h0);
        chk("rst_ramaddr", ramaddr,     32'h0);
        #11 nRST = 1'b1;

        // 2: single fetch, two BUSY cycles then ACCESS
        iREN = 2'b01; iaddr[31:0] = 32'h40; ramstate = BUSY; ramload = 32'hDEADBEEF;
        #1 chk("f_idle_iwait", 32'(iwait), 32'h3);
        step;
        chk("f_b1_addr",  ramaddr,      32'h40);
        chk("f_b1_ren",   32'(ramREN),  32'h1);
        chk("f_b1_iwait", 32'(iwait),   32'h3);
        step;
        chk("f_b2_addr",  ramaddr,      32'h40);
        chk("f_b2_iwait", 32'(iwait),   32'h3);
        ramstate = ACCESS;
        #1;
        chk("f_acc_addr",  ramaddr,      32'h40);
        chk("f_acc_iwait", 32'(iwait),   32'h2);
        chk("f_acc_iload", iload[31:0],  32'hDEADBEEF);
        chk("f_acc_iload1", iload[63:32], 32'h0);
        step;
        iREN = 2'b00; ramstate = FREE;
        #1;
        chk("f_post_iwait", 32'(iwait),  32'h3);
        chk("f_post_ren",   32'(ramREN), 32'h0);
        chk("f_post_iload", iload[31:0], 32'h0);

        // 3: d write on core 1 beats i fetch on core 0
        iREN = 2'b01; dWEN = 2'b10; daddr[63:32] = 32'h100; dstore[63:32] = 32'h12345678;
        ramstate = ACCESS; ramload = 32'hCAFEF00D;
        #1 chk("p_idle_wen", 32'(ramWEN), 32'h0);
        step;
        chk("p_w_wen",   32'(ramWEN), 32'h1);
        chk("p_w_ren",   32'(ramREN), 32'h0);
        chk("p_w_addr",  ramaddr,     32'h100);
        chk("p_w_store", ramstore,    32'h12345678);
        chk("p_w_dwait", 32'(dwait),  32'h1);
        chk("p_w_iwait", 32'(iwait),  32'h3);
        step;
        dWEN = 2'b00;
        #1 chk("p_gap_dwait", 32'(dwait), 32'h3);
        step;
        chk("p_f_ren",   32'(ramREN), 32'h1);
        chk("p_f_addr",  ramaddr,     32'h40);
        chk("p_f_iwait", 32'(iwait),  32'h2);
        chk("p_f_iload", iload[31:0], 32'hCAFEF00D);
        step;
        iREN = 2'b00;

        // async reset in the middle of a grant
        iREN = 2'b01; ramstate = BUSY;
        step;
        chk("ar_pre_ren", 32'(ramREN), 32'h1);
        #1 nRST = 1'b0;
        #1;
        chk("ar_ren",   32'(ramREN), 32'h0);
        chk("ar_iwait", 32'(iwait),  32'h3);
        chk("ar_addr",  ramaddr,     32'h0);
        #1 nRST = 1'b1;
        iREN = 2'b00;

        // 4: round-robin between two fetching cores, immediate ACCESS
        iREN = 2'b11; iaddr[63:32] = 32'h80; ramstate = ACCESS;
        for (int k = 0; k < 4; k++) begin
            ramload = 32'hA0000000 + 32'(k);
            step;
            if (k % 2 == 0) begin
                chk("rr_iwait", 32'(iwait),  32'h2);
                chk("rr_addr",  ramaddr,     32'h40);
                chk("rr_iload", iload[31:0], 32'hA0000000 + 32'(k));
            end else begin
                chk("rr_iwait", 32'(iwait),   32'h1);
                chk("rr_addr",  ramaddr,      32'h80);
                chk("rr_iload", iload[63:32], 32'hA0000000 + 32'(k));
            end
            step;
            chk("rr_gap_iwait", 32'(iwait), 32'h3);
        end
        iREN = 2'b00;

        // 5: ERROR retries, then requester abandons the fetch
        iREN = 2'b01; ramstate = ERROR;
        step;
        for (int k = 0; k < 3; k++) begin
            chk("err_iwait", 32'(iwait),  32'h3);
            chk("err_ren",   32'(ramREN), 32'h1);
            step;
        end
        iREN = 2'b00; ramstate = ACCESS;
        #1;
        chk("ab_ren",   32'(ramREN), 32'h0);
        chk("ab_iwait", 32'(iwait),  32'h3);
        step;
        chk("ab_idle_iwait", 32'(iwait),  32'h3);
        chk("ab_idle_ren",   32'(ramREN), 32'h0);
        step;
        chk("ab_idle2_iwait", 32'(iwait), 32'h3);

        // dWEN beats dREN on one core, then a plain read returns ramload
        dREN = 2'b10; dWEN = 2'b10; daddr[63:32] = 32'h100; dstore[63:32] = 32'h55AA55AA;
        ramload = 32'h0BADF00D;
        step;
        chk("rw_wen",   32'(ramWEN),  32'h1);
        chk("rw_ren",   32'(ramREN),  32'h0);
        chk("rw_store", ramstore,     32'h55AA55AA);
        chk("rw_dwait", 32'(dwait),   32'h1);
        chk("rw_dload", dload[63:32], 32'h0);
        step;
        dWEN = 2'b00;
        step;
        chk("rd_ren",   32'(ramREN),  32'h1);
        chk("rd_wen",   32'(ramWEN),  32'h0);
        chk("rd_addr",  ramaddr,      32'h100);
        chk("rd_store", ramstore,     32'h0);
        chk("rd_dwait", 32'(dwait),   32'h1);
        chk("rd_dload", dload[63:32], 32'h0BADF00D);
        step;
        dREN = 2'b00;

        // 6: 5 fetches by core 1, 2 writes by core 0 from a fresh reset
        nRST = 1'b0;
        #1 nRST = 1'b1;
        iREN = 2'b10; ramstate = ACCESS;
        for (int k = 0; k < 5; k++) begin
            step;
            chk("s_f_iwait", 32'(iwait), 32'h1);
            step;
        end
        iREN = 2'b00;
        dWEN = 2'b01; daddr[31:0] = 32'h300; dstore[31:0] = 32'h0F0F0F0F;
        for (int k = 0; k < 2; k++) begin
            step;
            chk("s_w_dwait", 32'(dwait),  32'h2);
            chk("s_w_wen",   32'(ramWEN), 32'h1);
            step;
        end
        dWEN = 2'b00;
        step;
`ifdef MEM_ARBITER_STATS_EN
        chk("istat0", istat[31:0],  32'd0);
        chk("istat1", istat[63:32], 32'd5);
        chk("dstat0", dstat[31:0],  32'd2);
        chk("dstat1", dstat[63:32], 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
